// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and access sequencer sharing one data memory between the core and the loader
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        core_mcontrol,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_done,
    output logic              core_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_grant,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t     state;
    logic       owner_ld;
    logic       last_ld;
    logic       we_q;
    logic [2:0] cnt;
    logic       core_req;
    logic       grant_ld;
    logic       grant_we;
    assign core_req   = core_mcontrol == 2'b01 || core_mcontrol == 2'b10;
    assign grant_ld   = ld_req && (!core_req || !last_ld);
    assign grant_we   = grant_ld ? ld_we : core_mcontrol == 2'b10;
    assign core_stall = core_req && !core_done;
    // mem_addr/mem_wdata double as the captured request; mem_en/mem_we are only raised for the ISSUE cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner_ld   <= 1'b0;
            last_ld    <= 1'b1;
            we_q       <= 1'b0;
            cnt        <= 3'd0;
            core_rdata <= '0;
            ld_rdata   <= '0;
            core_done  <= 1'b0;
            ld_done    <= 1'b0;
            ld_grant   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: if (core_req || ld_req) begin
                    state     <= ISSUE;
                    owner_ld  <= grant_ld;
                    last_ld   <= grant_ld;
                    we_q      <= grant_we;
                    mem_en    <= 1'b1;
                    mem_we    <= grant_we;
                    mem_addr  <= grant_ld ? ld_addr : core_addr;
                    mem_wdata <= grant_ld ? ld_wdata : core_wdata;
                    ld_grant  <= grant_ld;
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (we_q) begin
                        state     <= DONE;
                        core_done <= !owner_ld;
                        ld_done   <= owner_ld;
                    end else begin
                        state <= WAIT;
                        cnt   <= 3'(RD_LAT - 1);
                    end
                end
                WAIT: if (cnt == 3'd0) begin
                    state     <= DONE;
                    core_done <= !owner_ld;
                    ld_done   <= owner_ld;
                    if (owner_ld) ld_rdata <= mem_rdata;
                    else core_rdata <= mem_rdata;
                end else begin
                    cnt <= cnt - 3'd1;
                end
                DONE: begin
                    state     <= IDLE;
                    core_done <= 1'b0;
                    ld_done   <= 1'b0;
                    ld_grant  <= 1'b0;
                end
            endcase
        end
    end
endmodule
